// File: rtl/ps2_rx_ctrl.sv
// PS/2 host receive controller: synchronises ps2_clk/ps2_dat, deframes 11-bit
// frames and queues good scancodes in a show-ahead FIFO with sticky fault flags.
module ps2_rx_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 4000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_dat,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic                          rd_valid,
    output logic [7:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [2:0]  ck_sync, dt_sync;
    logic        ck_prev;
    logic        fall, din, timeout;
    logic [12:0] to_cnt;

    state_t      state, state_nxt;
    logic [2:0]  bit_cnt, bit_nxt;
    logic [7:0]  shreg, sh_nxt;
    logic        par_ok, par_nxt;
    logic        push, set_perr, set_ferr;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, pop, wr_ok, set_ovf;

    // Stage 2 of each synchroniser is the sampled value; ck_prev holds the prior one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ck_sync <= 3'b111;
            dt_sync <= 3'b111;
            ck_prev <= 1'b1;
        end else begin
            ck_sync <= {ck_sync[1:0], ps2_clk};
            dt_sync <= {dt_sync[1:0], ps2_dat};
            ck_prev <= ck_sync[2];
        end
    end

    assign fall = ck_prev & ~ck_sync[2];
    assign din  = dt_sync[2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            to_cnt <= '0;
        else if (fall || state == IDLE)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 13'd1;
    end

    assign timeout = (state != IDLE) && (to_cnt == 13'(TIMEOUT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_ok  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= sh_nxt;
            par_ok  <= par_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        sh_nxt    = shreg;
        par_nxt   = par_ok;
        push      = 1'b0;
        set_perr  = 1'b0;
        set_ferr  = 1'b0;
        if (timeout) begin
            state_nxt = IDLE;
            sh_nxt    = '0;
            set_ferr  = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!din) begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                    end
                end
                DATA: begin
                    sh_nxt[bit_cnt] = din;
                    bit_nxt         = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_nxt = PARITY;
                end
                PARITY: begin
                    par_nxt   = ^{shreg, din};
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (!din)
                        set_ferr = 1'b1;
                    else if (!par_ok)
                        set_perr = 1'b1;
                    else
                        push = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A push into a full FIFO still lands when the head is popped in the same cycle.
    assign count    = wr_ptr - rd_ptr;
    assign rd_valid = (count != '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign pop      = rd_en & rd_valid;
    assign wr_ok    = push & (~full | pop);
    assign set_ovf  = push & full & ~pop;
    assign rd_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr[AW-1:0]] <= shreg;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (set_perr)     parity_err <= 1'b1;
            else if (clr_err) parity_err <= 1'b0;
            if (set_ferr)     frame_err  <= 1'b1;
            else if (clr_err) frame_err  <= 1'b0;
            if (set_ovf)      overflow   <= 1'b1;
            else if (clr_err) overflow   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Bench for ps2_rx_ctrl: drives PS/2 frames (directed + random) and checks the
// DUT against a queue-based model of frame outcomes and FIFO contents.
`timescale 1ns/1ps
module tb_ps2_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int TO    = 4000;
    localparam int H     = 8;

    logic       clock = 1'b0;
    logic       reset, ps2_clk, ps2_dat, rd_en, clr_err;
    logic       rd_valid, parity_err, frame_err, overflow;
    logic [7:0] rd_data;
    logic [3:0] count;

    ps2_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .rd_en(rd_en), .clr_err(clr_err), .rd_valid(rd_valid), .rd_data(rd_data),
        .count(count), .parity_err(parity_err), .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    byte unsigned q[$];
    bit m_perr, m_ferr, m_ovf;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_state();
        chk("count", 16'(count), 16'(q.size()));
        chk("rd_valid", 16'(rd_valid), 16'(q.size() != 0));
        if (q.size() != 0)
            chk("rd_data", 16'(rd_data), 16'(q[0]));
        chk("parity_err", 16'(parity_err), 16'(m_perr));
        chk("frame_err", 16'(frame_err), 16'(m_ferr));
        chk("overflow", 16'(overflow), 16'(m_ovf));
    endtask

    task automatic drive_bit(input bit b);
        ps2_dat = b;
        tick(H);
        ps2_clk = 1'b0;
        tick(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input byte unsigned d, input bit bad_par,
                              input bit bad_stop, input bit pop_at_push);
        bit par, stop, popped;
        int n0;
        par  = ~(^d) ^ bad_par;
        stop = ~bad_stop;
        n0   = q.size();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(d[i]);
        drive_bit(par);
        ps2_dat = stop;
        tick(H);
        ps2_clk = 1'b0;
        // push lands on the 4th clock edge after the stop-bit low is driven
        tick(3);
        chk("lat_before", 16'(count), 16'(n0));
        popped = pop_at_push && (n0 != 0);
        if (pop_at_push) begin
            if (n0 != 0)
                chk("head_at_push", 16'(rd_data), 16'(q[0]));
            rd_en = 1'b1;
        end
        tick(1);
        rd_en = 1'b0;
        if (popped)
            void'(q.pop_front());
        if (!stop)
            m_ferr = 1'b1;
        else if (bad_par)
            m_perr = 1'b1;
        else if (n0 == DEPTH && !popped)
            m_ovf = 1'b1;
        else
            q.push_back(d);
        chk("lat_after", 16'(count), 16'(q.size()));
        tick(H - 4);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        tick(H);
        check_state();
    endtask

    task automatic pop_one();
        chk("pop_valid", 16'(rd_valid), 16'(q.size() != 0));
        if (q.size() != 0)
            chk("pop_data", 16'(rd_data), 16'(q[0]));
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        if (q.size() != 0)
            void'(q.pop_front());
        check_state();
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        check_state();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        q.delete();
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        check_state();
        chk("rst_rd_data", 16'(rd_data), 16'h0);
        reset = 1'b0;
        tick(3);
    endtask

    initial begin
        byte unsigned d;
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        tick(3);
        do_reset();
        check_state();

        // single good frame, then pop
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        pop_one();

        // continuous 0xFF traffic with no reads: saturate then overflow
        for (int i = 0; i < DEPTH + 2; i++)
            send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            pop_one();
        pop_one();
        clear_flags();

        // parity fault then a good frame
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        pop_one();
        clear_flags();

        // bad stop bit
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        clear_flags();

        // stall after 4 data bits: frame_err only once the timeout expires
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++)
            drive_bit(1'b1);
        tick(TO - 100);
        chk("pre_timeout", 16'(frame_err), 16'h0);
        tick(200);
        m_ferr = 1'b1;
        check_state();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        pop_one();
        clear_flags();

        // full FIFO with a pop in the push cycle
        for (int i = 0; i < DEPTH; i++)
            send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++)
            pop_one();

        // reset in the middle of the DATA state
        send_frame(8'h12, 1'b0, 1'b0, 1'b0);
        send_frame(8'h77, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++)
            drive_bit(1'b0);
        do_reset();
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        pop_one();

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) pop_one();
            if ($urandom_range(0, 7) == 0)
                clear_flags();
        end
        while (q.size() != 0)
            pop_one();
        pop_one();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
